ss_result_collector: RTL and testbench



---
 rtl/ss_pkg.sv | 22 ++
 rtl/ss_result_collector_if.sv | 35 +++
 rtl/ss_result_buf.sv | 21 ++
 rtl/ss_result_collector.sv | 125 ++++++++++++
 tb/tb_ss_result_collector.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ss_pkg.sv
// Shared types and sizing for the systolic result path and its collector.
package ss_pkg;

  localparam int MM_OUT_W = 40;
  localparam int DATA_W   = MM_OUT_W;
  localparam int DEPTH    = 7;
  localparam int SUM_W    = DATA_W + $clog2(DEPTH);
  // Pointer must reach DEPTH itself so a full buffer is distinguishable.
  localparam int PTR_W    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } collector_state_e;

  function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ss_result_collector_if.sv
// Bundle between the multiply stage, the result collector and its consumer.
interface ss_result_collector_if;
  import ss_pkg::*;

  // Upstream side is a bare strobe (no ready): a beat exists whenever
  // in_valid is high. Downstream side is valid/ready: a beat transfers on a
  // rising edge where out_valid && out_ready; while out_valid is high and
  // out_ready low, out_value and out_last hold.
  logic                   in_valid;
  logic [DATA_W-1:0]      in_value;
  logic                   in_busy;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_value;
  logic                   out_last;
  logic [SUM_W-1:0]       out_sum;
  logic [DATA_W-1:0]      out_max;
  logic [PTR_W-1:0]       out_count;
  logic                   err_ovf;
  logic                   err_busy;
  collector_state_e       dbg_state;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_busy, out_valid, out_value, out_last, out_sum, out_max,
           out_count, err_ovf, err_busy, dbg_state
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_busy, out_valid, out_value, out_last, out_sum, out_max,
           out_count, err_ovf, err_busy, dbg_state
  );

endinterface

// File: rtl/ss_result_buf.sv
// Burst storage: synchronous write, combinational read, no reset on contents.
module ss_result_buf
  import ss_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ss_result_collector.sv
// Captures one anti-diagonal result burst, accumulates sum and max, then
// replays it downstream with the totals attached to the last beat.
module ss_result_collector
  import ss_pkg::*;
(
  input  logic clk,
  input  logic rst,
  ss_result_collector_if.slave bus
);

  collector_state_e  state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  count_q, count_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_busy_q, err_busy_d;

  logic              buf_we;
  logic [PTR_W-1:0]  buf_waddr;
  logic [DATA_W-1:0] buf_rdata;
  logic              draining;
  logic              is_last;
  logic              fire;

  ss_result_buf u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .wdata_i (bus.in_value),
    .raddr_i (rd_ptr_q),
    .rdata_o (buf_rdata)
  );

  assign draining = (state_q == DRAIN);
  assign is_last  = (rd_ptr_q == (count_q - PTR_W'(1)));
  assign fire     = draining && bus.out_ready;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    sum_d      = sum_q;
    max_d      = max_q;
    err_ovf_d  = err_ovf_q;
    err_busy_d = err_busy_q;
    buf_we     = 1'b0;
    buf_waddr  = wr_ptr_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          buf_we    = 1'b1;
          buf_waddr = '0;
          sum_d     = SUM_W'(bus.in_value);
          max_d     = bus.in_value;
          wr_ptr_d  = PTR_W'(1);
          state_d   = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.in_valid) begin
          if (wr_ptr_q < PTR_W'(DEPTH)) begin
            buf_we   = 1'b1;
            sum_d    = sum_q + SUM_W'(bus.in_value);
            max_d    = umax(max_q, bus.in_value);
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end else begin
            // Excess beats are discarded; totals describe the stored beats only.
            err_ovf_d = 1'b1;
          end
        end else begin
          count_d  = wr_ptr_q;
          rd_ptr_d = '0;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.in_valid) err_busy_d = 1'b1;
        if (fire) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          if (is_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sum_q      <= '0;
      max_q      <= '0;
      err_ovf_q  <= 1'b0;
      err_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
      err_ovf_q  <= err_ovf_d;
      err_busy_q <= err_busy_d;
    end
  end

  // Storage is unreset, so the data path is gated to keep outputs at 0 outside DRAIN.
  assign bus.in_busy   = draining;
  assign bus.out_valid = draining;
  assign bus.out_value = draining ? buf_rdata : '0;
  assign bus.out_last  = draining && is_last;
  assign bus.out_sum   = sum_q;
  assign bus.out_max   = max_q;
  assign bus.out_count = count_q;
  assign bus.err_ovf   = err_ovf_q;
  assign bus.err_busy  = err_busy_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_ss_result_collector.sv
// Directed, table-driven bench for ss_result_collector with a replay scoreboard.
module tb_ss_result_collector;
  import ss_pkg::*;

  localparam int NV = 7;

  typedef struct {
    int                n;
    logic [DATA_W-1:0] v [8];
    int                stall_at;
    int                stall_len;
    bit                busy_pulse;
    logic [SUM_W-1:0]  e_sum;
    logic [DATA_W-1:0] e_max;
    int                e_count;
    bit                e_ovf;
    bit                e_busy;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t vecs [NV];
  logic [DATA_W-1:0] exp_q [$];

  ss_result_collector_if bus ();

  ss_result_collector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: called at a negedge; leaves in_valid low at the negedge after the last beat.
  task automatic send_burst(input int k);
    for (int i = 0; i < vecs[k].n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_value = vecs[k].v[i];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_value = '0;
  endtask

  // Consumer: checks every replay cycle against the head of exp_q.
  task automatic drain(input int stall_at, input int stall_len, input bit busy_pulse,
                       input logic [SUM_W-1:0] e_sum, input logic [DATA_W-1:0] e_max,
                       input int e_count);
    int idx;
    int stall_left;
    int guard;
    logic [DATA_W-1:0] e_val;
    logic e_last;
    idx = 0;
    stall_left = stall_len;
    guard = 0;
    while (exp_q.size() > 0 && guard < 64) begin
      @(negedge clk);
      guard++;
      bus.in_valid = busy_pulse && (guard == 3);
      bus.in_value = bus.in_valid ? 40'hDE_ADBE_EF00 : '0;
      e_val  = exp_q[0];
      e_last = (exp_q.size() == 1);
      check("out_valid", 64'(bus.out_valid), 64'd1);
      check("in_busy", 64'(bus.in_busy), 64'd1);
      check("out_value", 64'(bus.out_value), 64'(e_val));
      check("out_last", 64'(bus.out_last), 64'(e_last));
      if (e_last) begin
        check("out_sum", 64'(bus.out_sum), 64'(e_sum));
        check("out_max", 64'(bus.out_max), 64'(e_max));
        check("out_count", 64'(bus.out_count), 64'(e_count));
      end
      if (idx == stall_at && stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = 1'b1;
        if (bus.out_valid) begin
          void'(exp_q.pop_front());
          idx++;
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.in_value = '0;
    if (exp_q.size() > 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("idle_valid", 64'(bus.out_valid), 64'd0);
    check("idle_busy", 64'(bus.in_busy), 64'd0);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_value  = '0;
    bus.out_ready = 1'b1;

    // Stimulus table
    for (int k = 0; k < NV; k++) begin
      for (int i = 0; i < 8; i++) vecs[k].v[i] = '0;
      vecs[k].stall_at = -1; vecs[k].stall_len = 0; vecs[k].busy_pulse = 1'b0;
      vecs[k].e_ovf = 1'b0; vecs[k].e_busy = 1'b0;
    end
    vecs[0].n = 3; vecs[0].v[0] = 40'd5; vecs[0].v[1] = 40'd17; vecs[0].v[2] = 40'd9;
    vecs[0].e_sum = 43'd31; vecs[0].e_max = 40'd17; vecs[0].e_count = 3;

    vecs[1].n = 7;
    for (int i = 0; i < 7; i++) vecs[1].v[i] = DATA_W'(i + 1);
    vecs[1].e_sum = 43'd28; vecs[1].e_max = 40'd7; vecs[1].e_count = 7;

    vecs[2].n = 3; vecs[2].v[0] = 40'd10; vecs[2].v[1] = 40'd20; vecs[2].v[2] = 40'd30;
    vecs[2].stall_at = 1; vecs[2].stall_len = 2;
    vecs[2].e_sum = 43'd60; vecs[2].e_max = 40'd30; vecs[2].e_count = 3;

    vecs[3].n = 7;
    for (int i = 0; i < 7; i++) vecs[3].v[i] = {DATA_W{1'b1}};
    vecs[3].e_sum = 43'h6FF_FFFF_FFF9; vecs[3].e_max = 40'hFF_FFFF_FFFF; vecs[3].e_count = 7;

    vecs[4].n = 8;
    for (int i = 0; i < 8; i++) vecs[4].v[i] = DATA_W'(i + 1);
    vecs[4].e_sum = 43'd28; vecs[4].e_max = 40'd7; vecs[4].e_count = 7; vecs[4].e_ovf = 1'b1;

    vecs[5].n = 7;
    for (int i = 0; i < 7; i++) vecs[5].v[i] = DATA_W'(7 - i);
    vecs[5].busy_pulse = 1'b1;
    vecs[5].e_sum = 43'd28; vecs[5].e_max = 40'd7; vecs[5].e_count = 7;
    vecs[5].e_ovf = 1'b1; vecs[5].e_busy = 1'b1;

    vecs[6].n = 1; vecs[6].v[0] = 40'd42;
    vecs[6].e_sum = 43'd42; vecs[6].e_max = 40'd42; vecs[6].e_count = 1;
    vecs[6].e_ovf = 1'b1; vecs[6].e_busy = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_busy", 64'(bus.in_busy), 64'd0);
    check("rst_out_value", 64'(bus.out_value), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_out_sum", 64'(bus.out_sum), 64'd0);
    check("rst_out_max", 64'(bus.out_max), 64'd0);
    check("rst_out_count", 64'(bus.out_count), 64'd0);
    check("rst_err_ovf", 64'(bus.err_ovf), 64'd0);
    check("rst_err_busy", 64'(bus.err_busy), 64'd0);
    check("rst_state", 64'(bus.dbg_state), 64'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven bursts, issued back to back
    for (int k = 0; k < NV; k++) begin
      exp_q.delete();
      for (int i = 0; i < vecs[k].n && i < DEPTH; i++) exp_q.push_back(vecs[k].v[i]);
      send_burst(k);
      drain(vecs[k].stall_at, vecs[k].stall_len, vecs[k].busy_pulse,
            vecs[k].e_sum, vecs[k].e_max, vecs[k].e_count);
      check($sformatf("err_ovf_v%0d", k), 64'(bus.err_ovf), 64'(vecs[k].e_ovf));
      check($sformatf("err_busy_v%0d", k), 64'(bus.err_busy), 64'(vecs[k].e_busy));
    end

    // Reset mid-drain after two of seven beats accepted
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(vecs[1].v[i]);
    send_burst(1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
      check("pre_rst_value", 64'(bus.out_value), 64'(exp_q.pop_front()));
    end
    @(negedge clk);
    check("pre_rst_value3", 64'(bus.out_value), 64'd3);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(bus.out_valid), 64'd0);
    check("async_rst_err_ovf", 64'(bus.err_ovf), 64'd0);
    check("async_rst_err_busy", 64'(bus.err_busy), 64'd0);
    check("async_rst_sum", 64'(bus.out_sum), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 64'(bus.out_valid), 64'd0);
    check("post_rst_state", 64'(bus.dbg_state), 64'(IDLE));

    // Fresh burst after reset
    vecs[0].v[0] = 40'd4; vecs[0].v[1] = 40'd4; vecs[0].v[2] = 40'd4;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(40'd4);
    send_burst(0);
    drain(-1, 0, 1'b0, 43'd12, 40'd4, 3);
    check("final_err_ovf", 64'(bus.err_ovf), 64'd0);
    check("final_err_busy", 64'(bus.err_busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
